joy_db15_tx: RTL and testbench
==============================

// Module: joy_db15_tx
// PURPOSE
// - Device end of the DB15 serial joystick link: the shift-register pad adapter that the joy_db15 reader polls.
// - Latches two 12-bit active-high button words on JOY_LOAD low.
// - Shifts the words out active-low on JOY_DATA, one bit per JOY_CLK rising edge.
// - Used as a loopback/bring-up source on USER_IO and as the bus-functional model in joy_db15 benches.
// - Runs on CLK_JOY (40-50 MHz). JOY_CLK/JOY_LOAD are asynchronous to it and are synchronized internally.
// PARAMETERS
// NBITS     12  bits per player word; frame length = 2*NBITS
// SYNC_FF    2  synchronizer depth on JOY_CLK and JOY_LOAD (>=2)
// FILT       3  clocks an input must be stable before it is accepted (glitch filter, 1..15)
// PORTS
// clk            in   1      CLK_JOY, 40-50 MHz
// reset          in   1      synchronous, active-high
// joystick1_in   in   NBITS  P1 buttons, 1=pressed; bit map FEDCBAUDLR (bit0=R)
// joystick2_in   in   NBITS  P2 buttons, same map
// JOY_CLK        in   1      shift clock from the reader; async
// JOY_LOAD       in   1      parallel load, active-low; async
// JOY_DATA       out  1      serial data, active-low (0=pressed)
// frame_done     out  1      1-clk pulse after the last (2*NBITS)th bit is shifted
// bit_cnt        out  5      bits shifted since the last load, saturates at 2*NBITS
// BEHAVIOUR
// - Reset values: JOY_DATA=1, frame_done=0, bit_cnt=0, shift register all 1s, filter state clk_f=0/load_f=1.
// - Input path:
//   - Each async input passes through SYNC_FF flops.
//   - Filtered value (clk_f/load_f) changes only after the synced value differs from it for FILT consecutive clocks.
//   - Edge detect is applied on the filtered value.
// - Shift register sr[2*NBITS-1:0]; JOY_DATA = sr[0] registered; serial fill value = 1.
// - LOAD (load_f==0, level-sensitive, transparent):
//   - Every clk: sr <= ~{joystick2_in, joystick1_in}, bit_cnt <= 0.
//   - JOY_CLK edges are ignored while load_f==0.
// - SHIFT: on rising edge of clk_f with load_f==1 and bit_cnt<2*NBITS:
//   - sr <= {1'b1, sr[2*NBITS-1:1]}; bit_cnt <= bit_cnt+1.
// - Bit order: first bit on JOY_DATA after load = ~P1[0]; bit NBITS = ~P2[0]; last = ~P2[NBITS-1].
// - frame_done: pulses the cycle bit_cnt goes 2*NBITS-1 -> 2*NBITS.
// - Overrun: clk_f edges once bit_cnt==2*NBITS shift 1s in.
//   - JOY_DATA=1 (released) after the frame.
//   - bit_cnt holds at 2*NBITS; no further frame_done.
// - Falling edges of clk_f: no action.
// - Simultaneous events: load_f falling in the same clk as a clk_f rising edge -> load wins, no shift, bit_cnt=0.
// - Load mid-frame: frame restarts. bit_cnt=0, sr reloaded; bits already sent are not re-sent from a partial state.
// - Button inputs change while load_f==1: no effect until next load (frame is a consistent snapshot).
// - Latency: JOY_CLK rising pin edge -> JOY_DATA update = SYNC_FF+FILT+1 clk cycles (6 at defaults, 120-150 ns).
//   - Readers must hold JOY_CLK high/low >= that time plus margin.
// - JOY_LOAD low -> first bit valid on JOY_DATA after SYNC_FF+FILT+1 clks.
// - Pulses shorter than FILT clks on either input are rejected entirely (no shift, no load).
// - reset mid-frame: returns to reset values next clk. With JOY_LOAD held low, the first load occurs FILT clks after reset release.
// - bit_cnt width 5 covers NBITS<=15; elaboration error otherwise.
// TESTING
// 1. Load P1=12'h015, P2=12'h820; pulse JOY_LOAD low; 24 JOY_CLK edges -> JOY_DATA sequence 0,1,0,1,0,1,1,1,1,1,1,1, 1,1,1,1,1,0,1,1,1,1,1,0; frame_done pulses once.
// 2. Loopback into joy_db15 reader with P1=12'hA5A, P2=12'h3C3 -> joystick1[11:0]=12'hA5A, joystick2[11:0]=12'h3C3 on every poll for 100 frames.
// 3. 30 JOY_CLK edges after load -> edges 25-30 give JOY_DATA=1; bit_cnt holds 24; exactly one frame_done.
// 4. JOY_LOAD pulse after 7 shifts -> bit_cnt=0; next bit out = ~P1[0] of the new snapshot.
// 5. 2-clk glitch on JOY_CLK and on JOY_LOAD (FILT=3) -> no shift, no load; 3-clk pulse -> accepted.
// 6. Assert reset after 10 shifts -> next clk JOY_DATA=1, bit_cnt=0, frame_done=0; with JOY_LOAD low on release, first bit = ~P1[0] after 6 clks.

Source files
------------

// File: rtl/joy_db15_tx.sv
// rtl/joy_db15_tx.sv - DB15 joystick pad adapter: parallel load, active-low serial shift out
module joy_db15_tx #(
    parameter int NBITS   = 12,
    parameter int SYNC_FF = 2,
    parameter int FILT    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NBITS-1:0] joystick1_in,
    input  logic [NBITS-1:0] joystick2_in,
    input  logic             JOY_CLK,
    input  logic             JOY_LOAD,
    output logic             JOY_DATA,
    output logic             frame_done,
    output logic [4:0]       bit_cnt
);

    localparam int         W          = 2 * NBITS;
    localparam logic [4:0] FRAME_LEN  = 5'(W);
    localparam logic [4:0] FRAME_LAST = 5'(W - 1);
    localparam logic [3:0] FILT_LAST  = 4'(FILT - 1);

    if (NBITS < 1 || NBITS > 15) begin : g_bad_nbits
        $error("joy_db15_tx: NBITS must be 1..15");
    end
    if (SYNC_FF < 2) begin : g_bad_sync
        $error("joy_db15_tx: SYNC_FF must be >= 2");
    end
    if (FILT < 1 || FILT > 15) begin : g_bad_filt
        $error("joy_db15_tx: FILT must be 1..15");
    end

    logic [SYNC_FF-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_FF-1:0] load_sync_q, load_sync_d;
    logic               clk_f_q, clk_f_d;
    logic               load_f_q, load_f_d;
    logic [3:0]         clk_cnt_q, clk_cnt_d;
    logic [3:0]         load_cnt_q, load_cnt_d;
    logic [W-1:0]       sr_q, sr_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic               frame_done_q, frame_done_d;
    logic               joy_data_q, joy_data_d;
    logic               clk_s, load_s, clk_rise;

    assign clk_s  = clk_sync_q[SYNC_FF-1];
    assign load_s = load_sync_q[SYNC_FF-1];

    // Synchronizer shift chains; left out of reset so a held JOY_LOAD is already settled on release
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_FF-2:0], JOY_CLK};
        load_sync_d = {load_sync_q[SYNC_FF-2:0], JOY_LOAD};
    end

    // Synchronizer flops
    always_ff @(posedge clk) begin
        clk_sync_q  <= clk_sync_d;
        load_sync_q <= load_sync_d;
    end

    // Glitch filters: the filtered value flips on the FILT-th consecutive clock of disagreement
    always_comb begin
        clk_f_d    = clk_f_q;
        clk_cnt_d  = 4'd0;
        load_f_d   = load_f_q;
        load_cnt_d = 4'd0;
        if (clk_s != clk_f_q) begin
            if (clk_cnt_q == FILT_LAST) begin
                clk_f_d = clk_s;
            end else begin
                clk_cnt_d = clk_cnt_q + 4'd1;
            end
        end
        if (load_s != load_f_q) begin
            if (load_cnt_q == FILT_LAST) begin
                load_f_d = load_s;
            end else begin
                load_cnt_d = load_cnt_q + 4'd1;
            end
        end
    end

    // Shift datapath: transparent load dominates; rising filtered clock shifts 1s in from the top
    always_comb begin
        clk_rise     = clk_f_d & ~clk_f_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        frame_done_d = 1'b0;
        joy_data_d   = sr_q[0];
        if (!load_f_d) begin
            sr_d      = ~{joystick2_in, joystick1_in};
            bit_cnt_d = 5'd0;
        end else if (clk_rise) begin
            sr_d = {1'b1, sr_q[W-1:1]};
            if (bit_cnt_q < FRAME_LEN) begin
                bit_cnt_d    = bit_cnt_q + 5'd1;
                frame_done_d = (bit_cnt_q == FRAME_LAST);
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_f_q      <= 1'b0;
            load_f_q     <= 1'b1;
            clk_cnt_q    <= 4'd0;
            load_cnt_q   <= 4'd0;
            sr_q         <= '1;
            bit_cnt_q    <= 5'd0;
            frame_done_q <= 1'b0;
            joy_data_q   <= 1'b1;
        end else begin
            clk_f_q      <= clk_f_d;
            load_f_q     <= load_f_d;
            clk_cnt_q    <= clk_cnt_d;
            load_cnt_q   <= load_cnt_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            frame_done_q <= frame_done_d;
            joy_data_q   <= joy_data_d;
        end
    end

    assign JOY_DATA   = joy_data_q;
    assign frame_done = frame_done_q;
    assign bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
// tb/tb_joy_db15_tx.sv - directed self-checking bench for joy_db15_tx
module tb_joy_db15_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] joystick1_in = 12'h000;
    logic [11:0] joystick2_in = 12'h000;
    logic        JOY_CLK = 1'b0;
    logic        JOY_LOAD = 1'b1;
    logic        JOY_DATA;
    logic        frame_done;
    logic [4:0]  bit_cnt;

    int checks = 0;
    int failures = 0;
    int fd_cnt = 0;

    joy_db15_tx #(.NBITS(12), .SYNC_FF(2), .FILT(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .joystick1_in (joystick1_in),
        .joystick2_in (joystick2_in),
        .JOY_CLK      (JOY_CLK),
        .JOY_LOAD     (JOY_LOAD),
        .JOY_DATA     (JOY_DATA),
        .frame_done   (frame_done),
        .bit_cnt      (bit_cnt)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt = fd_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load();
        JOY_LOAD = 1'b0;
        tick(8);
        JOY_LOAD = 1'b1;
        tick(8);
    endtask

    task automatic shift_pulse();
        JOY_CLK = 1'b1;
        tick(8);
        JOY_CLK = 1'b0;
        tick(8);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(5);
        checks++;
        if (JOY_DATA !== 1'b1) begin
            failures++;
            $display("FAIL reset_data got=%0b exp=1", JOY_DATA);
        end
        checks++;
        if (frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_frame_done got=%0b exp=0", frame_done);
        end
        checks++;
        if (bit_cnt !== 5'd0) begin
            failures++;
            $display("FAIL reset_bit_cnt got=%0d exp=0", bit_cnt);
        end
        reset = 1'b0;
        tick(4);
    endtask

    // P1=015, P2=820: sequence 0,1,0,1,0,1,1,1,1,1,1,1, 1,1,1,1,1,0,1,1,1,1,1,0
    task automatic test_frame();
        logic [23:0] exp_seq;
        exp_seq = 24'h7DFFEA;
        joystick1_in = 12'h015;
        joystick2_in = 12'h820;
        do_load();
        joystick1_in = 12'hFFF;
        joystick2_in = 12'h5A5;
        fd_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            checks++;
            if (JOY_DATA !== exp_seq[i]) begin
                failures++;
                $display("FAIL frame_bit%0d got=%0b exp=%0b", i, JOY_DATA, exp_seq[i]);
            end
            shift_pulse();
        end
        checks++;
        if (bit_cnt !== 5'd24) begin
            failures++;
            $display("FAIL frame_bit_cnt got=%0d exp=24", bit_cnt);
        end
        checks++;
        if (JOY_DATA !== 1'b1) begin
            failures++;
            $display("FAIL frame_released got=%0b exp=1", JOY_DATA);
        end
        checks++;
        if (fd_cnt !== 1) begin
            failures++;
            $display("FAIL frame_done_count got=%0d exp=1", fd_cnt);
        end
    endtask

    // P1=000 so every P1 bit reads as 1, P2=FFF so every P2 bit reads as 0
    task automatic test_overrun();
        joystick1_in = 12'h000;
        joystick2_in = 12'hFFF;
        do_load();
        fd_cnt = 0;
        for (int i = 1; i <= 30; i++) begin
            shift_pulse();
            if (i == 23) begin
                checks++;
                if (JOY_DATA !== 1'b0) begin
                    failures++;
                    $display("FAIL overrun_last_bit got=%0b exp=0", JOY_DATA);
                end
            end
            if (i >= 24) begin
                checks++;
                if (JOY_DATA !== 1'b1) begin
                    failures++;
                    $display("FAIL overrun_edge%0d got=%0b exp=1", i, JOY_DATA);
                end
                checks++;
                if (bit_cnt !== 5'd24) begin
                    failures++;
                    $display("FAIL overrun_cnt_edge%0d got=%0d exp=24", i, bit_cnt);
                end
            end
        end
        checks++;
        if (fd_cnt !== 1) begin
            failures++;
            $display("FAIL overrun_frame_done_count got=%0d exp=1", fd_cnt);
        end
    endtask

    // P1=0F0: after 7 shifts bit7=1 is out (data 0); reload with P1=FFE gives data 1
    task automatic test_midload();
        joystick1_in = 12'h0F0;
        joystick2_in = 12'h000;
        do_load();
        repeat (7) shift_pulse();
        checks++;
        if (bit_cnt !== 5'd7) begin
            failures++;
            $display("FAIL midload_cnt7 got=%0d exp=7", bit_cnt);
        end
        checks++;
        if (JOY_DATA !== 1'b0) begin
            failures++;
            $display("FAIL midload_bit7 got=%0b exp=0", JOY_DATA);
        end
        joystick1_in = 12'hFFE;
        do_load();
        checks++;
        if (bit_cnt !== 5'd0) begin
            failures++;
            $display("FAIL midload_cnt_reload got=%0d exp=0", bit_cnt);
        end
        checks++;
        if (JOY_DATA !== 1'b1) begin
            failures++;
            $display("FAIL midload_first_bit got=%0b exp=1", JOY_DATA);
        end
    endtask

    // P1 bit0=1, bit1=0: data goes 0 -> 1 exactly 6 clks after the JOY_CLK pin rises
    task automatic test_latency();
        joystick1_in = 12'h001;
        joystick2_in = 12'h000;
        do_load();
        JOY_CLK = 1'b1;
        tick(5);
        checks++;
        if (JOY_DATA !== 1'b0) begin
            failures++;
            $display("FAIL latency_early got=%0b exp=0", JOY_DATA);
        end
        tick(1);
        checks++;
        if (JOY_DATA !== 1'b1) begin
            failures++;
            $display("FAIL latency_6clk got=%0b exp=1", JOY_DATA);
        end
        JOY_CLK = 1'b0;
        tick(8);
    endtask

    task automatic test_glitch();
        joystick1_in = 12'h00A;
        joystick2_in = 12'h000;
        do_load();
        JOY_CLK = 1'b1;
        tick(2);
        JOY_CLK = 1'b0;
        tick(10);
        checks++;
        if (bit_cnt !== 5'd0) begin
            failures++;
            $display("FAIL glitch_clk2 got=%0d exp=0", bit_cnt);
        end
        JOY_CLK = 1'b1;
        tick(3);
        JOY_CLK = 1'b0;
        tick(10);
        checks++;
        if (bit_cnt !== 5'd1) begin
            failures++;
            $display("FAIL glitch_clk3 got=%0d exp=1", bit_cnt);
        end
        JOY_LOAD = 1'b0;
        tick(2);
        JOY_LOAD = 1'b1;
        tick(10);
        checks++;
        if (bit_cnt !== 5'd1) begin
            failures++;
            $display("FAIL glitch_load2 got=%0d exp=1", bit_cnt);
        end
        JOY_LOAD = 1'b0;
        tick(3);
        JOY_LOAD = 1'b1;
        tick(10);
        checks++;
        if (bit_cnt !== 5'd0) begin
            failures++;
            $display("FAIL glitch_load3 got=%0d exp=0", bit_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        joystick1_in = 12'h3C1;
        joystick2_in = 12'h000;
        do_load();
        repeat (10) shift_pulse();
        checks++;
        if (bit_cnt !== 5'd10) begin
            failures++;
            $display("FAIL rstmid_cnt10 got=%0d exp=10", bit_cnt);
        end
        reset = 1'b1;
        JOY_LOAD = 1'b0;
        tick(1);
        checks++;
        if (JOY_DATA !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_data got=%0b exp=1", JOY_DATA);
        end
        checks++;
        if (bit_cnt !== 5'd0) begin
            failures++;
            $display("FAIL rstmid_cnt got=%0d exp=0", bit_cnt);
        end
        checks++;
        if (frame_done !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_frame_done got=%0b exp=0", frame_done);
        end
        tick(4);
        reset = 1'b0;
        tick(6);
        checks++;
        if (JOY_DATA !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_first_bit got=%0b exp=0", JOY_DATA);
        end
        JOY_LOAD = 1'b1;
        tick(8);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_overrun();
        test_midload();
        test_latency();
        test_glitch();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
